// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
//   Request/response front end for a single-port tri-state memory. Accepts
//   one valid/ready request at a time, performs a single-cycle read or write
//   on the memory and returns exactly one response per request.
//
//   Optional feature macro: MEM_CTRL_VERIFY_EN
//     When defined, every write is followed by a one-cycle read-back of the
//     same address. The read-back word is returned in rsp_rdata, and rsp_err
//     flags a difference from the written data. When undefined, there is no
//     read-back state, write responses carry rsp_rdata=0, and rsp_err is tied
//     to 0.
//
//   Strobe/bus rules:
//     - mem_rd, mem_wr, mem_addr and the bus enable are all registered and
//       are decoded from the state transition. rd and wr are therefore never
//       high in the same cycle.
//     - mem_data is driven only while mem_wr is high; otherwise every bit is
//       released to Z.
//     - mem_addr keeps its last value between accesses.
// ---------------------------------------------------------------------------
module mem_ctrl #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,

    // request stream
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,

    // response stream
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,

    // memory side
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data
);

    // -----------------------------------------------------------------------
    // State encoding. The read-back state only exists when the feature is
    // compiled in, so it is given the highest code and appended last.
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ   = 3'd2,
        ST_RESP   = 3'd3
`ifdef MEM_CTRL_VERIFY_EN
        ,
        ST_VERIFY = 3'd4
`endif
    } state_t;

    state_t              state_reg;

    // Registered outputs.
    logic                req_ready_reg;
    logic                rsp_valid_reg;
    logic [DWIDTH-1:0]   rsp_rdata_reg;
    logic                mem_rd_reg;
    logic                mem_wr_reg;
    logic [AWIDTH-1:0]   mem_addr_reg;

    // Bus enable tracks mem_wr but is kept as its own flop so the tri-state
    // enable stays a clean register output feeding the pad drivers.
    logic                bus_en_reg;

    // Write data latched at acceptance. Driven onto the bus during WRITE and,
    // with read-back enabled, used as the reference for the compare.
    logic [DWIDTH-1:0]   wdata_reg;

`ifdef MEM_CTRL_VERIFY_EN
    logic                rsp_err_reg;
`endif

    // -----------------------------------------------------------------------
    // Controller FSM: sequences the memory access and owns every output
    // register. Requests are only looked at in IDLE; everything else ignores
    // the request inputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            mem_rd_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            bus_en_reg    <= 1'b0;
            wdata_reg     <= '0;
`ifdef MEM_CTRL_VERIFY_EN
            rsp_err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                // Wait for a request; latch it and raise the proper strobe
                // so the access happens in the very next cycle.
                ST_IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        req_ready_reg <= 1'b0;
                        mem_addr_reg  <= req_addr;
                        wdata_reg     <= req_wdata;
                        if (req_we) begin
                            state_reg  <= ST_WRITE;
                            mem_wr_reg <= 1'b1;
                            bus_en_reg <= 1'b1;
                        end else begin
                            state_reg  <= ST_READ;
                            mem_rd_reg <= 1'b1;
                        end
                    end
                end

                // The memory stores the word at the edge that leaves this
                // state. Drop the write strobe and release the bus together.
                ST_WRITE: begin
                    mem_wr_reg <= 1'b0;
                    bus_en_reg <= 1'b0;
`ifdef MEM_CTRL_VERIFY_EN
                    // Read the same address straight back.
                    state_reg  <= ST_VERIFY;
                    mem_rd_reg <= 1'b1;
`else
                    state_reg     <= ST_RESP;
                    rsp_valid_reg <= 1'b1;
                    rsp_rdata_reg <= '0;
`endif
                end

                // The memory drives the bus during this cycle; capture it.
                ST_READ: begin
                    mem_rd_reg    <= 1'b0;
                    rsp_rdata_reg <= mem_data;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= ST_RESP;
`ifdef MEM_CTRL_VERIFY_EN
                    // A plain read never reports a compare error.
                    rsp_err_reg   <= 1'b0;
`endif
                end

`ifdef MEM_CTRL_VERIFY_EN
                // Read-back of the word just written: return it and flag any
                // difference from what was sent.
                ST_VERIFY: begin
                    mem_rd_reg    <= 1'b0;
                    rsp_rdata_reg <= mem_data;
                    rsp_err_reg   <= (mem_data != wdata_reg);
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= ST_RESP;
                end
`endif

                // Hold the response stable until the consumer takes it, then
                // reopen the request side on the following cycle.
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end

                // Unreachable codes: park safely with the bus released.
                default: begin
                    state_reg     <= ST_IDLE;
                    req_ready_reg <= 1'b1;
                    rsp_valid_reg <= 1'b0;
                    mem_rd_reg    <= 1'b0;
                    mem_wr_reg    <= 1'b0;
                    bus_en_reg    <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output wiring.
    // -----------------------------------------------------------------------
    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign mem_rd    = mem_rd_reg;
    assign mem_wr    = mem_wr_reg;
    assign mem_addr  = mem_addr_reg;

`ifdef MEM_CTRL_VERIFY_EN
    assign rsp_err   = rsp_err_reg;
`else
    // Without read-back there is nothing that could mismatch.
    assign rsp_err   = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Per-bit tri-state drivers for the shared data bus. Every bit shares the
    // same registered enable, so the whole word turns on and off together.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DWIDTH; gi++) begin : g_bus_drv
            assign mem_data[gi] = bus_en_reg ? wdata_reg[gi] : 1'bz;
        end
    endgenerate

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl
//   Self-checking bench for mem_ctrl. A behavioural tri-state memory sits on
//   the bus, and a plain reference array tracks what the memory should hold.
//   Compile with +define+MEM_CTRL_VERIFY_EN to exercise the read-back build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_ctrl;

    localparam int AW = 5;
    localparam int DW = 8;
`ifdef MEM_CTRL_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif
    // Edges from acceptance until rsp_valid is seen high.
    localparam int LAT_W = VER ? 3 : 2;
    localparam int LAT_R = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;

    int n_cmp = 0;
    int n_err = 0;
    int both_seen = 0;

    // Behavioural memory and reference contents.
    logic [DW-1:0] mem_array [2**AW];
    logic [DW-1:0] ref_mem   [2**AW];
    logic [DW-1:0] stuck_mask = '0;

    mem_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read drive, write at the clock edge.
    assign mem_data = mem_rd ? (mem_array[mem_addr] ^ stuck_mask) : {DW{1'bz}};
    always @(posedge clk) begin
        if (mem_wr) mem_array[mem_addr] <= mem_data;
    end

    // Strobe exclusivity monitor, sampled every cycle.
    always @(negedge clk) begin
        if (mem_rd && mem_wr) both_seen++;
    end

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            mem_array[i] = '0;
            ref_mem[i]   = '0;
        end
    end

    // One request through the DUT. Returns what was observed; callers judge.
    task automatic do_req(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int stall,
                          output logic [DW-1:0] rd, output logic er,
                          output int lat, output int nwr, output int nrd,
                          output logic [AW-1:0] saddr, output logic [DW-1:0] sdata,
                          output logic held, output logic tmo);
        int guard;
        tmo = 1'b0; held = 1'b1; nwr = 0; nrd = 0; lat = 0;
        rd = '0; er = 1'b0; saddr = '0; sdata = '0;
        rsp_ready = (stall == 0);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        // Scramble the now-ignored request inputs.
        req_valid = 1'b0; req_we = 1'($urandom);
        req_addr = AW'($urandom); req_wdata = DW'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            if (mem_wr) begin nwr++; saddr = mem_addr; sdata = mem_data; end
            if (mem_rd) begin nrd++; saddr = mem_addr; end
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            tmo = 1'b1;
            rsp_ready = 1'b1;
            return;
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (!(rsp_valid && !req_ready && !mem_rd && !mem_wr)) held = 1'b0;
        end
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        $display("txn we=%0d addr=%0d wdata=%h rdata=%h err=%0d lat=%0d stall=%0d",
                 we, addr, wd, rd, er, lat, stall);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== '0)   begin n_err++; $display("FAIL reset_rsp_rdata got %h want 00", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0)   begin n_err++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        n_cmp++; if (mem_rd !== 1'b0)    begin n_err++; $display("FAIL reset_mem_rd got %b want 0", mem_rd); end
        n_cmp++; if (mem_wr !== 1'b0)    begin n_err++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
        n_cmp++; if (mem_addr !== '0)    begin n_err++; $display("FAIL reset_mem_addr got %0d want 0", mem_addr); end
    endtask

    task automatic test_write_basic();
        logic [DW-1:0] rd, sd; logic er, held, tmo; logic [AW-1:0] sa; int lat, nwr, nrd;
        do_req(1'b1, 5'd3, 8'hA5, 0, rd, er, lat, nwr, nrd, sa, sd, held, tmo);
        ref_mem[3] = 8'hA5;
        n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL wr_timeout no response"); end
        n_cmp++; if (nwr !== 1) begin n_err++; $display("FAIL wr_strobe_cycles got %0d want 1", nwr); end
        n_cmp++; if (sa !== 5'd3) begin n_err++; $display("FAIL wr_addr got %0d want 3", sa); end
        n_cmp++; if (sd !== 8'hA5) begin n_err++; $display("FAIL wr_bus_data got %h want a5", sd); end
        n_cmp++; if (lat !== LAT_W) begin n_err++; $display("FAIL wr_latency got %0d want %0d", lat, LAT_W); end
        n_cmp++; if (nrd !== (VER ? 1 : 0)) begin n_err++; $display("FAIL wr_rd_strobes got %0d want %0d", nrd, VER ? 1 : 0); end
        n_cmp++; if (rd !== (VER ? 8'hA5 : 8'h00)) begin n_err++; $display("FAIL wr_rsp_rdata got %h want %h", rd, VER ? 8'hA5 : 8'h00); end
        n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL wr_rsp_err got %b want 0", er); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_rsp_one_cycle got %b want 0", rsp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_return got %b want 1", req_ready); end
    endtask

    task automatic test_read_basic();
        logic [DW-1:0] rd, sd; logic er, held, tmo; logic [AW-1:0] sa; int lat, nwr, nrd;
        do_req(1'b0, 5'd3, 8'h00, 0, rd, er, lat, nwr, nrd, sa, sd, held, tmo);
        n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL rd_timeout no response"); end
        n_cmp++; if (nrd !== 1 || nwr !== 0) begin n_err++; $display("FAIL rd_strobes got rd=%0d wr=%0d want rd=1 wr=0", nrd, nwr); end
        n_cmp++; if (sa !== 5'd3) begin n_err++; $display("FAIL rd_addr got %0d want 3", sa); end
        n_cmp++; if (lat !== LAT_R) begin n_err++; $display("FAIL rd_latency got %0d want %0d", lat, LAT_R); end
        n_cmp++; if (rd !== 8'hA5) begin n_err++; $display("FAIL rd_data got %h want a5", rd); end
        n_cmp++; if (er !== 1'b0) begin n_err++; $display("FAIL rd_err got %b want 0", er); end
    endtask

    task automatic test_backpressure();
        int guard;
        logic [DW-1:0] rd, sd; logic er, held, tmo; logic [AW-1:0] sa; int lat, nwr, nrd;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd31; req_wdata = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        ref_mem[31] = 8'h3C;
        guard = 0;
        while (!rsp_valid && guard < 10) begin @(negedge clk); guard++; end
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_timeout rsp_valid got %b want 1", rsp_valid); end
        for (int c = 0; c < 5; c++) begin
            // A write pulse to address 5 during the stall must be ignored.
            if (c == 1) begin req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd5; req_wdata = 8'hFF; end
            else req_valid = 1'b0;
            @(negedge clk);
            n_cmp++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold cycle %0d got valid=%b ready=%b want 1/0", c, rsp_valid, req_ready); end
            n_cmp++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0) begin n_err++; $display("FAIL bp_no_access cycle %0d got rd=%b wr=%b want 0/0", c, mem_rd, mem_wr); end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
        do_req(1'b0, 5'd31, 8'h00, 0, rd, er, lat, nwr, nrd, sa, sd, held, tmo);
        n_cmp++; if (rd !== 8'h3C) begin n_err++; $display("FAIL bp_readback got %h want 3c", rd); end
        do_req(1'b0, 5'd5, 8'h00, 0, rd, er, lat, nwr, nrd, sa, sd, held, tmo);
        n_cmp++; if (rd !== ref_mem[5]) begin n_err++; $display("FAIL bp_ignored_write got %h want %h", rd, ref_mem[5]); end
    endtask

    task automatic test_reset_mid_write();
        logic [DW-1:0] rd, sd; logic er, held, tmo; logic [AW-1:0] sa; int lat, nwr, nrd;
        int spurious;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd7; req_wdata = 8'h11;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        ref_mem[7] = 8'h11;
        n_cmp++; if (mem_wr !== 1'b1) begin n_err++; $display("FAIL rstw_in_write got %b want 1", mem_wr); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstw_handshake got ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
        n_cmp++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0) begin n_err++; $display("FAIL rstw_strobes got rd=%b wr=%b want 0/0", mem_rd, mem_wr); end
        n_cmp++; if (mem_addr !== '0 || rsp_rdata !== '0 || rsp_err !== 1'b0) begin n_err++; $display("FAIL rstw_values got addr=%0d rdata=%h err=%b want 0/00/0", mem_addr, rsp_rdata, rsp_err); end
        spurious = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid || mem_rd || mem_wr) spurious++;
        end
        n_cmp++; if (spurious !== 0) begin n_err++; $display("FAIL rstw_no_response got %0d active cycles want 0", spurious); end
        do_req(1'b0, 5'd7, 8'h00, 0, rd, er, lat, nwr, nrd, sa, sd, held, tmo);
        n_cmp++; if (rd !== 8'h11) begin n_err++; $display("FAIL rstw_write_kept got %h want 11", rd); end
    endtask

`ifdef MEM_CTRL_VERIFY_EN
    task automatic test_verify();
        logic [DW-1:0] rd, sd; logic er, held, tmo; logic [AW-1:0] sa; int lat, nwr, nrd;
        do_req(1'b1, 5'd0, 8'h5A, 0, rd, er, lat, nwr, nrd, sa, sd, held, tmo);
        ref_mem[0] = 8'h5A;
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL vfy_latency got %0d want 3", lat); end
        n_cmp++; if (rd !== 8'h5A || er !== 1'b0) begin n_err++; $display("FAIL vfy_clean got rdata=%h err=%b want 5a/0", rd, er); end
        stuck_mask = 8'h01;
        do_req(1'b1, 5'd1, 8'h5A, 0, rd, er, lat, nwr, nrd, sa, sd, held, tmo);
        stuck_mask = 8'h00;
        ref_mem[1] = 8'h5A;
        n_cmp++; if (er !== 1'b1) begin n_err++; $display("FAIL vfy_stuck_err got %b want 1", er); end
        n_cmp++; if (rd !== 8'h5B) begin n_err++; $display("FAIL vfy_stuck_data got %h want 5b", rd); end
    endtask
`endif

    task automatic test_random();
        logic [DW-1:0] rd, sd, wd, exp_rd; logic er, held, tmo, we;
        logic [AW-1:0] sa, addr; int lat, nwr, nrd, stall, exp_lat;
        for (int i = 0; i < 1000; i++) begin
            we    = 1'($urandom_range(0, 1));
            addr  = AW'($urandom_range(0, 2**AW - 1));
            wd    = DW'($urandom);
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            exp_rd  = we ? (VER ? wd : '0) : ref_mem[addr];
            exp_lat = we ? LAT_W : LAT_R;
            do_req(we, addr, wd, stall, rd, er, lat, nwr, nrd, sa, sd, held, tmo);
            if (we) ref_mem[addr] = wd;
            n_cmp++; if (tmo !== 1'b0 || lat !== exp_lat) begin n_err++; $display("FAIL rnd_latency op %0d got %0d (tmo=%b) want %0d", i, lat, tmo, exp_lat); end
            n_cmp++; if (rd !== exp_rd || er !== 1'b0) begin n_err++; $display("FAIL rnd_data op %0d we=%0d addr=%0d got %h/%b want %h/0", i, we, addr, rd, er, exp_rd); end
            n_cmp++; if (sa !== addr) begin n_err++; $display("FAIL rnd_addr op %0d got %0d want %0d", i, sa, addr); end
            n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL rnd_stall_hold op %0d got %b want 1", i, held); end
        end
        n_cmp++; if (both_seen !== 0) begin n_err++; $display("FAIL rd_wr_overlap got %0d cycles want 0", both_seen); end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_backpressure();
        test_reset_mid_write();
`ifdef MEM_CTRL_VERIFY_EN
        test_verify();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
